// File: rtl/pb_evt_pkg.sv
// Shared types for the button event scheduler: event kinds and their field width.
package pb_evt_pkg;

  localparam int KIND_W = 2;

  // Encoding doubles as the index of the pending bit within a button's group.
  typedef enum logic [KIND_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_kind_t;

endpackage

// File: rtl/pb_evt_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry while not empty.
module pb_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pb_event_scheduler.sv
// Gathers press/long/release events from N_BTN debouncers, arbitrates them
// round-robin into a small FIFO and hands them out over valid/ready.
module pb_event_scheduler
  import pb_evt_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int LONG_PRESS = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         pressed_pulse,
  input  logic [N_BTN-1:0]         released_pulse,
  input  logic [N_BTN-1:0]         pressed_status,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [KIND_W-1:0]        evt_kind,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int BTN_W  = $clog2(N_BTN);
  localparam int CNT_W  = $clog2(LONG_PRESS+1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [BTN_W-1:0] btn;
    evt_kind_t        kind;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  logic [N_BTN-1:0][2:0] trig, pend_q, pend_d, gnt;
  logic [BTN_W-1:0]      rr_q, rr_d, win, cand;
  evt_kind_t             kind_sel;
  logic                  found, grant, coalesce, pop, can_push;
  logic                  overflow_q, overflow_d;
  logic                  fifo_full, fifo_empty;
  logic [FCNT_W-1:0]     fifo_count;
  evt_t                  push_evt, head_evt;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             long_trig;

      always_comb begin
        cnt_d = '0;
        if (pressed_status[gi])
          cnt_d = (cnt_q == CNT_W'(LONG_PRESS)) ? cnt_q : cnt_q + 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      // Saturation at LONG_PRESS keeps this to a single firing per hold.
      assign long_trig = pressed_status[gi] && (cnt_q == CNT_W'(LONG_PRESS-1));
      assign trig[gi]  = {released_pulse[gi], long_trig, pressed_pulse[gi]};
    end
  endgenerate

  assign pop      = evt_valid && evt_ready;
  assign can_push = (fifo_count < FCNT_W'(FIFO_DEPTH)) || (fifo_full && pop);

  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    kind_sel = EVT_PRESS;
    gnt      = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cand = BTN_W'((int'(rr_q) + i) % N_BTN);
      if (!found && (|pend_q[cand])) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (pend_q[win][0])      kind_sel = EVT_PRESS;
    else if (pend_q[win][1]) kind_sel = EVT_LONG;
    else                     kind_sel = EVT_RELEASE;
    grant = found && can_push;
    gnt[win][kind_sel] = grant;
  end

  // A trigger landing on its own grant re-arms the bit rather than coalescing.
  assign pend_d     = (pend_q & ~gnt) | trig;
  assign coalesce   = |(trig & pend_q & ~gnt);
  assign rr_d       = !grant ? rr_q : (win == BTN_W'(N_BTN-1)) ? '0 : win + 1'b1;
  assign overflow_d = coalesce ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  assign push_evt = '{btn: win, kind: kind_sel};

  pb_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (pop),
    .din   (push_evt),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid = !fifo_empty;
  assign evt_btn   = head_evt.btn;
  assign evt_kind  = head_evt.kind;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pb_event_scheduler.sv
// Directed bench for pb_event_scheduler (N_BTN=8, LONG_PRESS=8, FIFO_DEPTH=4).
module tb_pb_event_scheduler;

  localparam int N  = 8;
  localparam int LP = 8;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pp  = '0;
  logic [N-1:0] rp  = '0;
  logic [N-1:0] ps  = '0;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [2:0]   evt_btn;
  logic [1:0]   evt_kind;
  logic         overflow;
  logic         overflow_clr = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int got_btn  [32];
  int got_kind [32];
  int got_at   [32];
  int n_got;

  pb_event_scheduler #(
    .N_BTN      (N),
    .LONG_PRESS (LP),
    .FIFO_DEPTH (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pressed_pulse  (pp),
    .released_pulse (rp),
    .pressed_status (ps),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_btn        (evt_btn),
    .evt_kind       (evt_kind),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Logs an accepted head entry observed in the current cycle.
  task automatic rec(input int k);
    if (evt_valid && evt_ready && n_got < 32) begin
      got_btn[n_got]  = int'(evt_btn);
      got_kind[n_got] = int'(evt_kind);
      got_at[n_got]   = k;
      $display("[TB] cycle %0d evt btn=%0d kind=%0d", k, evt_btn, evt_kind);
      n_got++;
    end
  endtask

  task automatic collect(input int cycles);
    n_got = 0;
    for (int c = 0; c < cycles; c++) begin
      rec(c);
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    tests_run++;
    if (evt_btn !== 3'd0 || evt_kind !== 2'd0) begin
      tests_failed++; $display("FAIL reset_head got btn=%0d kind=%0d want 0/0", evt_btn, evt_kind);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid got %0b want 0", evt_valid); end
  endtask

  task automatic test_latency();
    evt_ready = 1'b1;
    pp[2] = 1'b1;
    tick();
    pp = '0;
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_t1 got valid=%0b want 0", evt_valid); end
    tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_btn !== 3'd2 || evt_kind !== 2'd0) begin
      tests_failed++;
      $display("FAIL latency_t2 got valid=%0b btn=%0d kind=%0d want 1/2/0", evt_valid, evt_btn, evt_kind);
    end else $display("[TB] evt btn=%0d kind=%0d", evt_btn, evt_kind);
    tick();
    tests_run++;
    if (evt_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_t3 got valid=%0b want 0", evt_valid); end
  endtask

  task automatic test_long_press();
    evt_ready = 1'b1;
    n_got = 0;
    for (int k = 0; k < 32; k++) begin
      ps[1] = (k < 20);
      rp[1] = (k == 20);
      rec(k);
      tick();
    end
    rp = '0;
    tests_run++;
    if (n_got !== 2) begin tests_failed++; $display("FAIL long_count got %0d want 2", n_got); end
    tests_run++;
    if (got_at[0] !== 9 || got_btn[0] !== 1 || got_kind[0] !== 1) begin
      tests_failed++;
      $display("FAIL long_event got at=%0d btn=%0d kind=%0d want 9/1/1", got_at[0], got_btn[0], got_kind[0]);
    end
    tests_run++;
    if (got_at[1] !== 22 || got_btn[1] !== 1 || got_kind[1] !== 2) begin
      tests_failed++;
      $display("FAIL release_event got at=%0d btn=%0d kind=%0d want 22/1/2", got_at[1], got_btn[1], got_kind[1]);
    end
    // Seven held cycles is one short of the threshold.
    n_got = 0;
    for (int k = 0; k < 20; k++) begin
      ps[1] = (k < 7);
      rec(k);
      tick();
    end
    tests_run++;
    if (n_got !== 0) begin tests_failed++; $display("FAIL short_hold got %0d events want 0", n_got); end
  endtask

  task automatic test_round_robin();
    // rr_ptr is 2 here: the last grant went to button 1.
    evt_ready = 1'b1;
    pp = 8'b0000_1011;
    tick();
    pp = '0;
    collect(10);
    tests_run++;
    if (n_got !== 3 || got_btn[0] !== 3 || got_btn[1] !== 0 || got_btn[2] !== 1) begin
      tests_failed++;
      $display("FAIL rr_order got n=%0d order %0d,%0d,%0d want 3:3,0,1", n_got, got_btn[0], got_btn[1], got_btn[2]);
    end
  endtask

  task automatic test_full_fifo();
    int exp_btn [6];
    exp_btn = '{2, 4, 5, 7, 0, 1};
    evt_ready = 1'b0;
    pp = 8'b1011_0111;
    tick();
    pp = '0;
    repeat (6) tick();
    tests_run++;
    if (evt_valid !== 1'b1 || evt_btn !== 3'd2) begin
      tests_failed++; $display("FAIL full_head got valid=%0b btn=%0d want 1/2", evt_valid, evt_btn);
    end
    evt_ready = 1'b1;
    collect(15);
    tests_run++;
    if (n_got !== 6) begin tests_failed++; $display("FAIL full_count got %0d want 6", n_got); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (got_btn[i] !== exp_btn[i] || got_kind[i] !== 0) begin
        tests_failed++;
        $display("FAIL full_order[%0d] got btn=%0d kind=%0d want %0d/0", i, got_btn[i], got_kind[i], exp_btn[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL full_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_coalesce();
    int exp_btn [5];
    exp_btn = '{2, 3, 4, 5, 0};
    evt_ready = 1'b0;
    pp = 8'b0011_1100;
    tick();
    pp = '0;
    repeat (5) tick();
    pp[0] = 1'b1;
    tick();
    pp = '0;
    tick();
    tick();
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL coalesce_pre got %0b want 0", overflow); end
    pp[0] = 1'b1;
    tick();
    pp = '0;
    tick();
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL coalesce_set got %0b want 1", overflow); end
    evt_ready = 1'b1;
    collect(15);
    tests_run++;
    if (n_got !== 5) begin tests_failed++; $display("FAIL coalesce_count got %0d want 5", n_got); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (got_btn[i] !== exp_btn[i] || got_kind[i] !== 0) begin
        tests_failed++;
        $display("FAIL coalesce_order[%0d] got btn=%0d kind=%0d want %0d/0", i, got_btn[i], got_kind[i], exp_btn[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky got %0b want 1", overflow); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL overflow_clr got %0b want 0", overflow); end
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0;
    pp = 8'hF0;
    tick();
    pp = '0;
    repeat (5) tick();
    pp[0] = 1'b1;
    tick();
    pp = '0;
    tick();
    pp[0] = 1'b1;
    tick();
    pp = '0;
    tests_run++;
    if (evt_valid !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++; $display("FAIL arst_pre got valid=%0b ovf=%0b want 1/1", evt_valid, overflow);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL arst_now got valid=%0b ovf=%0b want 0/0", evt_valid, overflow);
    end
    #2 rst = 1'b0;
    evt_ready = 1'b1;
    tick();
    collect(12);
    tests_run++;
    if (n_got !== 0) begin tests_failed++; $display("FAIL arst_stale got %0d events want 0", n_got); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_long_press();
    test_round_robin();
    test_full_fifo();
    test_coalesce();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
